avalon_pio_irq: RTL
===================

Name: avalon_pio_irq

Overview:
- Parametrised Avalon-MM slave PIO, the next generation of the fixed 8-bit LED output port.
- Provides a WIDTH-bit output port with atomic set/clear, and a WIDTH-bit synchronised input port.
- Input edges are captured per bit, and a maskable, level-sensitive interrupt is raised to the processor.
- Sits on the system interconnect alongside the anemometer peripherals, driving LEDs and reading switches/buttons.

Parameters:
- WIDTH, 8: output and input port width, 1..32; readdata bits above WIDTH read 0.
- OUT_RESET, 0: reset value of the output register, WIDTH bits.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- EDGE_TYPE, 0: capture mode. 0 = rising, 1 = falling, 2 = any edge.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address (read latency 0).
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output register contents.
- irq  out  1  interrupt, active-high, level.

Behaviour:
- Register map (word addresses):
  - 0 DATA_OUT, RW.
  - 1 DATA_IN, RO; writes ignored.
  - 2 IRQ_MASK, RW.
  - 3 EDGE_CAP, read; write-1-to-clear.
  - 4 OUT_SET, WO; write ORs writedata into DATA_OUT.
  - 5 OUT_CLR, WO; write clears DATA_OUT bits where writedata=1.
  - 6 and 7 reserved: read 0, writes ignored. Addresses 4 and 5 also read 0.
- Reset values (reset=1 at a clk edge):
  - DATA_OUT = OUT_RESET.
  - IRQ_MASK = 0, EDGE_CAP = 0.
  - Synchroniser and previous-sample registers = 0.
  - Settle counter = 0, so irq=0 and out_port=OUT_RESET from the first edge with reset high.
- Writes:
  - Take effect on the clk edge where the write is sampled; out_port changes in the following cycle.
  - Only writedata[WIDTH-1:0] is used.
- Input path:
  - in_port passes through a SYNC_STAGES flop chain; the last stage is DATA_IN.
  - Latency from in_port change to DATA_IN = SYNC_STAGES cycles.
  - A prev register holds DATA_IN delayed by one cycle.
- Edge detection:
  - rise = DATA_IN & ~prev; fall = ~DATA_IN & prev; any = rise | fall. EDGE_TYPE selects which one is used.
  - Detection is gated by a settle counter. It counts 0..SYNC_STAGES+1 after reset and saturates; detection is enabled only when saturated.
  - This prevents spurious captures after reset when inputs are already high.
- EDGE_CAP bit n is sticky:
  - It sets on a detected edge of bit n.
  - It clears only by writing 1 to bit n at address 3, or by reset.
  - If a detected edge and a clear of the same bit occur in the same cycle, set wins and the bit stays 1.
- irq = OR over bits of (EDGE_CAP & IRQ_MASK).
  - Combinational from registers; updates the cycle after EDGE_CAP or IRQ_MASK changes.
  - Masking does not clear EDGE_CAP.
- Reset asserted mid-operation overrides any simultaneous write or edge.
- readdata is 0 when chipselect=0.

Decomposition:
- Shared package avalon_pio_pkg holds:
  - address constants ADDR_DATA_OUT..ADDR_OUT_CLR;
  - edge-type constants EDGE_RISE, EDGE_FALL, EDGE_ANY.
- One sub-module, pio_sync_edge, contains the synchroniser, prev register, settle counter and edge select. It outputs data_sync[WIDTH] and edge_pulse[WIDTH].
- The top level holds the register file, read mux and irq.

Test Plan (WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0 unless noted):
1. Reset, then write 0xA5 to addr 0 → out_port=0xA5 next cycle; read addr 0 returns 0x000000A5.
2. With out_port=0xA5:
   - write 0x0A to addr 4 → out_port=0xAF;
   - then write 0x81 to addr 5 → out_port=0x2E;
   - reads of addr 4 and 5 return 0.
3. Hold in_port=0xFF through reset and release → EDGE_CAP stays 0x00 and irq=0; read addr 1 returns 0xFF after 2 cycles.
4. Rising edge of in_port bit 3 with IRQ_MASK=0x08 → EDGE_CAP=0x08 and irq=1 within 4 cycles. Write 0x08 to addr 3 → EDGE_CAP=0, irq=0 the next cycle.
5. Clear write of bit 3 in the same cycle a new edge on bit 3 is detected → EDGE_CAP bit 3 remains 1.
6. EDGE_TYPE=2: pulse in_port bit 0 high for 5 cycles → EDGE_CAP=0x01 after the rise. Clear it, and the fall re-sets it. With IRQ_MASK=0, irq stays 0 throughout.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// avalon_pio_pkg: register addresses and edge-capture modes shared by the PIO block.
package avalon_pio_pkg;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: input synchroniser with settle-gated per-bit edge detection.
module pio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data_sync,
    output logic [WIDTH-1:0] edge_pulse
);
    import avalon_pio_pkg::*;
    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SYNC_STAGES + 1);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev <= data_sync;
            r_cnt  <= (r_cnt == SETTLE_MAX) ? r_cnt : r_cnt + CW'(1);
        end
    end
    assign data_sync = r_sync[SYNC_STAGES-1];
    assign w_rise    = data_sync & ~r_prev;
    assign w_fall    = ~data_sync & r_prev;
    // Held off until the chain and prev have both filled, so inputs high at reset never look like edges.
    assign edge_pulse = (r_cnt != SETTLE_MAX) ? '0 :
                        (EDGE_TYPE == EDGE_FALL) ? w_fall :
                        (EDGE_TYPE == EDGE_ANY)  ? (w_rise | w_fall) : w_rise;
endmodule

// File: rtl/avalon_pio_irq.sv
// avalon_pio_irq: Avalon-MM PIO with atomic set/clear outputs, synchronised inputs and
// sticky edge capture feeding a maskable level interrupt.
module avalon_pio_irq #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    import avalon_pio_pkg::*;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] w_data_in;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd;
    logic             w_wr;
    logic             w_unused;
    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .data_sync  (w_data_in),
        .edge_pulse (w_edge)
    );
    assign w_wr     = chipselect & ~write_n;
    assign w_wd     = writedata[WIDTH-1:0];
    assign w_unused = ^writedata;
    assign w_clr    = (w_wr && address == ADDR_EDGE_CAP) ? w_wd : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= OUT_RESET;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
        end else begin
            r_data_out <= !w_wr                     ? r_data_out :
                          address == ADDR_DATA_OUT ? w_wd :
                          address == ADDR_OUT_SET  ? (r_data_out | w_wd) :
                          address == ADDR_OUT_CLR  ? (r_data_out & ~w_wd) : r_data_out;
            r_irq_mask <= (w_wr && address == ADDR_IRQ_MASK) ? w_wd : r_irq_mask;
            // A fresh edge beats a simultaneous write-1-to-clear of the same bit.
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
        end
    end
    always_comb begin
        w_rd = address == ADDR_DATA_OUT ? r_data_out :
               address == ADDR_DATA_IN  ? w_data_in :
               address == ADDR_IRQ_MASK ? r_irq_mask :
               address == ADDR_EDGE_CAP ? r_edge_cap : '0;
        readdata = chipselect ? 32'(w_rd) : '0;
    end
    assign out_port = r_data_out;
    assign irq      = |(r_edge_cap & r_irq_mask);
endmodule
